// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared types, defaults and width helper for the register-bank write path
package regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int DEF_NREG = 8;
    localparam int DEF_AW   = 3;

    // Width of a requester index; never narrower than one bit.
    function automatic int ow_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after the last winner
module rr_pick #(
    parameter int NREQ = 2,
    parameter int OW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   last,
    output logic [OW-1:0]   winner,
    output logic            valid
);

    logic          hi_found;
    logic          lo_found;
    logic [OW-1:0] hi_idx;
    logic [OW-1:0] lo_idx;

    // Lowest requester above last wins; otherwise wrap to the lowest at or below last.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last)) begin
                    hi_found = 1'b1;
                    hi_idx   = OW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = OW'(i);
                end
            end
        end
        valid  = hi_found | lo_found;
        winner = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - round-robin write arbiter with bounded locked bursts for the 8-bit register bank
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int NREG      = DEF_NREG,
    parameter int AW        = DEF_AW,
    parameter int MAX_BURST = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            lock,
    input  logic [NREQ*AW-1:0]         addr,
    input  logic [NREQ*8-1:0]          wdata,
    output logic [NREQ-1:0]            ack,
    output logic                       err,
    output logic [NREG-1:0]            wr_en,
    output logic [7:0]                 wr_data,
    output logic                       busy,
    output logic [ow_width(NREQ)-1:0]  owner
);

    localparam int OW = ow_width(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t          state;
    state_t          state_next;
    logic [OW-1:0]   last;
    logic [BW-1:0]   bcnt;
    logic [BW-1:0]   bcnt_inc;
    logic [BW-1:0]   bcnt_next;
    logic [AW-1:0]   addr_q;
    logic [7:0]      data_q;

    logic [OW-1:0]   pick_winner;
    logic            pick_valid;
    logic [OW-1:0]   src;
    logic            load;
    logic [AW-1:0]   sel_addr;
    logic [7:0]      sel_data;
    logic            req_own;
    logic            lock_own;
    logic            is_write;
    logic [NREG-1:0] match;

    rr_pick #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_rr_pick (
        .req    (req),
        .last   (last),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // In IDLE the round-robin winner is latched; in LOCKED only the owner can be.
    assign src = (state == ST_IDLE) ? pick_winner : owner;

    // Select the source requester's address/data and the owner's req/lock bits.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        req_own  = 1'b0;
        lock_own = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (src == OW'(i)) begin
                sel_addr = addr[i*AW +: AW];
                sel_data = wdata[i*8 +: 8];
            end
            if (owner == OW'(i)) begin
                req_own  = req[i];
                lock_own = lock[i];
            end
        end
    end

    // Burst counter advance, saturating at MAX_BURST.
    assign bcnt_inc = (bcnt == BW'(MAX_BURST)) ? bcnt : bcnt + 1'b1;

    // Next-state logic: grant in IDLE, one-cycle WRITE, owner-only service in LOCKED.
    always_comb begin
        state_next = state;
        bcnt_next  = bcnt;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    load       = 1'b1;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (lock_own && (bcnt_inc < BW'(MAX_BURST))) begin
                    state_next = ST_LOCKED;
                    bcnt_next  = bcnt_inc;
                end else begin
                    state_next = ST_IDLE;
                    bcnt_next  = '0;
                end
            end
            ST_LOCKED: begin
                if (req_own) begin
                    load       = 1'b1;
                    state_next = ST_WRITE;
                end else if (!lock_own) begin
                    state_next = ST_IDLE;
                    bcnt_next  = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                bcnt_next  = '0;
            end
        endcase
    end

    // State, ownership and transfer latches; reset drops any write in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            last   <= OW'(NREQ - 1);
            owner  <= '0;
            bcnt   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_next;
            bcnt  <= bcnt_next;
            if (load) begin
                owner  <= src;
                last   <= src;
                addr_q <= sel_addr;
                data_q <= sel_data;
            end
        end
    end

    assign is_write = (state == ST_WRITE);

    // Address decode from the latched address; no match means out of range.
    always_comb begin
        match = '0;
        for (int r = 0; r < NREG; r++) begin
            match[r] = (addr_q == AW'(r));
        end
    end

    // Outputs decoded purely from state and latches.
    always_comb begin
        ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = is_write && (owner == OW'(i));
        end
        wr_en   = is_write ? match : '0;
        err     = is_write && !(|match);
        wr_data = is_write ? data_q : 8'h00;
        busy    = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb/tb_regbank_write_arbiter.sv - self-checking bench for regbank_write_arbiter
module tb_regbank_write_arbiter;
    import regbank_pkg::*;

    localparam int NREQ      = 2;
    localparam int NREG      = 8;
    localparam int AW        = 4;
    localparam int MAX_BURST = 4;
    localparam int OW        = ow_width(NREQ);
    localparam int AWB       = NREQ * AW;
    localparam int DWB       = NREQ * 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req   = '0;
    logic [NREQ-1:0] lock  = '0;
    logic [AWB-1:0]  addr  = '0;
    logic [DWB-1:0]  wdata = '0;
    logic [NREQ-1:0] ack;
    logic            err;
    logic [NREG-1:0] wr_en;
    logic [7:0]      wr_data;
    logic            busy;
    logic [OW-1:0]   owner;

    regbank_write_arbiter #(
        .NREQ      (NREQ),
        .NREG      (NREG),
        .AW        (AW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .lock    (lock),
        .addr    (addr),
        .wdata   (wdata),
        .ack     (ack),
        .err     (err),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .busy    (busy),
        .owner   (owner)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a pending write record plus who holds the lock.
    bit m_wv     = 1'b0;
    int m_waddr  = 0;
    int m_wdata  = 0;
    int m_holder = -1;
    int m_burst  = 0;
    int m_last   = NREQ - 1;
    int m_owner  = 0;

    logic [7:0]      reg_dut   [NREG];
    logic [7:0]      reg_model [NREG];
    logic [NREQ-1:0] ack_prev = '0;
    logic [NREQ-1:0] ack_done = '0;
    bit              rand_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [NREQ-1:0] with_bit(input logic [NREQ-1:0] v, input int i, input logic b);
        logic [NREQ-1:0] m;
        m = NREQ'(1) << i;
        return b ? (v | m) : (v & ~m);
    endfunction

    function automatic int get_addr(input int c);
        logic [AWB-1:0] t;
        t = addr >> (c * AW);
        return int'(t[AW-1:0]);
    endfunction

    function automatic int get_data(input int c);
        logic [DWB-1:0] t;
        t = wdata >> (c * 8);
        return int'(t[7:0]);
    endfunction

    task automatic set_xfer(input int i, input int a, input int d);
        logic [AWB-1:0] am;
        logic [DWB-1:0] dm;
        am    = AWB'((1 << AW) - 1) << (i * AW);
        dm    = DWB'(8'hFF) << (i * 8);
        addr  = (addr & ~am) | ((AWB'(a) << (i * AW)) & am);
        wdata = (wdata & ~dm) | ((DWB'(d) << (i * 8)) & dm);
        req   = with_bit(req, i, 1'b1);
    endtask

    task automatic model_take(input int c);
        m_wv    = 1'b1;
        m_waddr = get_addr(c);
        m_wdata = get_data(c);
    endtask

    // Advance the model by one clock edge using the inputs present before the edge.
    task automatic model_step();
        if (reset) begin
            m_wv     = 1'b0;
            m_holder = -1;
            m_burst  = 0;
            m_last   = NREQ - 1;
            m_owner  = 0;
        end else if (m_wv) begin
            m_wv    = 1'b0;
            m_burst = m_burst + 1;
            if (bit_of(lock, m_owner) && m_burst < MAX_BURST) begin
                m_holder = m_owner;
            end else begin
                m_holder = -1;
                m_burst  = 0;
            end
        end else if (m_holder >= 0) begin
            if (bit_of(req, m_holder)) begin
                model_take(m_holder);
            end else if (!bit_of(lock, m_holder)) begin
                m_holder = -1;
                m_burst  = 0;
            end
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (!m_wv && bit_of(req, c)) begin
                    model_take(c);
                    m_owner = c;
                    m_last  = c;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        logic [31:0] e_ack, e_err, e_wr_en, e_wd, e_busy;
        e_ack   = m_wv ? (32'd1 << m_owner) : 32'd0;
        e_err   = (m_wv && m_waddr >= NREG) ? 32'd1 : 32'd0;
        e_wr_en = (m_wv && m_waddr < NREG) ? (32'd1 << m_waddr) : 32'd0;
        e_wd    = m_wv ? 32'(m_wdata) : 32'd0;
        e_busy  = (m_wv || m_holder >= 0) ? 32'd1 : 32'd0;
        check("ack", 32'(ack), e_ack);
        check("err", 32'(err), e_err);
        check("wr_en", 32'(wr_en), e_wr_en);
        check("wr_data", 32'(wr_data), e_wd);
        check("busy", 32'(busy), e_busy);
        check("owner", 32'(owner), 32'(m_owner));
        for (int r = 0; r < NREG; r++) begin
            if (wr_en[r]) reg_dut[r] = wr_data;
        end
        if (m_wv && m_waddr < NREG) reg_model[m_waddr] = 8'(m_wdata);
    endtask

    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (bit_of(ack_done, i)) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_xfer(i, ($urandom_range(0, 9) == 0) ? int'($urandom_range(NREG, 15))
                                                             : int'($urandom_range(0, NREG - 1)),
                             int'($urandom_range(0, 255)));
                end else begin
                    req = with_bit(req, i, 1'b0);
                end
            end else if (!bit_of(req, i) && $urandom_range(0, 3) == 0) begin
                set_xfer(i, int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 7) == 0) lock = with_bit(lock, i, !bit_of(lock, i));
        end
        reset = ($urandom_range(0, 199) == 0);
    endtask

    // One clock: step the model at the edge, compare just after it, then drive.
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare_outputs();
        ack_done = ack_prev;
        ack_prev = ack;
        if (rand_mode) drive_random();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_alt [7];
        logic [1:0] exp_burst [9];
        for (int r = 0; r < NREG; r++) begin
            reg_dut[r]   = 8'h00;
            reg_model[r] = 8'h00;
        end

        // Reset state and a single write from requester 0.
        do_reset();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        set_xfer(0, 2, 8'hA5);
        tick();
        check("t1_wr_en", 32'(wr_en), 32'h04);
        check("t1_wr_data", 32'(wr_data), 32'hA5);
        check("t1_ack", 32'(ack), 32'h1);
        req = '0;
        tick();
        check("t1_reg2", 32'(reg_dut[2]), 32'hA5);

        // Both requesters held: strict alternation, one write per two cycles.
        do_reset();
        set_xfer(0, 4, 8'h40);
        set_xfer(1, 5, 8'h51);
        exp_alt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        for (int t = 0; t < 7; t++) begin
            tick();
            check("alt_ack", 32'(ack), 32'(exp_alt[t]));
        end
        req = '0;
        tick();

        // Locked burst by requester 1 capped at MAX_BURST, then requester 0.
        do_reset();
        lock = 2'b10;
        set_xfer(1, 1, 8'h10);
        exp_burst = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
        for (int t = 0; t < 9; t++) begin
            tick();
            check("burst_ack", 32'(ack), 32'(exp_burst[t]));
            if (t == 7) check("burst_idle_busy", 32'(busy), 32'd0);
            if (t == 0) set_xfer(0, 3, 8'h33);
            if (ack_done[1]) set_xfer(1, t % NREG, 8'h10 + t);
        end
        req  = '0;
        lock = '0;
        tick();

        // Out-of-range address: ack and err together, no write enable.
        do_reset();
        set_xfer(0, 9, 8'h3C);
        tick();
        check("oor_ack", 32'(ack), 32'h1);
        check("oor_err", 32'(err), 32'h1);
        check("oor_wr_en", 32'(wr_en), 32'h0);
        req = '0;
        tick();

        // Reset sampled at the end of WRITE, then a lone requester 1.
        do_reset();
        set_xfer(0, 1, 8'h77);
        tick();
        check("rw_ack", 32'(ack), 32'h1);
        reset = 1'b1;
        req   = '0;
        tick();
        check("rw_zero_ack", 32'(ack), 32'h0);
        check("rw_zero_wr_en", 32'(wr_en), 32'h0);
        check("rw_zero_wr_data", 32'(wr_data), 32'h0);
        check("rw_zero_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        set_xfer(1, 5, 8'h5A);
        tick();
        check("rw_ack1", 32'(ack), 32'h2);
        check("rw_wr_en1", 32'(wr_en), 32'h20);
        check("rw_owner1", 32'(owner), 32'h1);
        req = '0;
        tick();

        // Lock dropped with no request releases ownership and clears the burst.
        do_reset();
        lock = 2'b01;
        set_xfer(0, 0, 8'h0F);
        tick();
        req = '0;
        tick();
        check("drop_locked_busy", 32'(busy), 32'd1);
        lock = '0;
        tick();
        check("drop_idle_busy", 32'(busy), 32'd0);
        lock = 2'b01;
        set_xfer(0, 6, 8'h66);
        for (int t = 0; t < 8; t++) begin
            tick();
            check("drop_reburst_ack", 32'(ack), (t % 2 == 0) ? 32'h1 : 32'h0);
            check("drop_reburst_busy", 32'(busy), (t == 7) ? 32'd0 : 32'd1);
        end
        req  = '0;
        lock = '0;
        tick();

        // Randomized traffic against the model.
        do_reset();
        rand_mode = 1'b1;
        for (int n = 0; n < 4000; n++) tick();
        rand_mode = 1'b0;
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        for (int n = 0; n < 12; n++) tick();

        for (int r = 0; r < NREG; r++) begin
            check("regfile", 32'(reg_dut[r]), 32'(reg_model[r]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Write-side controller for the team's bank of 8-bit registers. It arbitrates register writes from up to NREQ requesters, such as the CPU core and the memory-editor UI, and grants one requester per transfer using round-robin. It drives one shared write-data bus plus one write-enable line per register instance. An optional lock lets the owning requester issue a bounded burst of writes without re-arbitrating.

## Interface
Parameters:
- NREQ, 2: number of requesters (≥2)
- NREG, 8: number of 8-bit registers driven
- AW, 3: address width; NREG ≤ 2^AW
- MAX_BURST, 4: maximum writes per locked ownership (≥1)

Ports:
- clock  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester write request
- lock  in  NREQ  per-requester request to keep ownership after the current write
- addr  in  NREQ*AW  per-requester register address, slice i = [i*AW +: AW]
- wdata  in  NREQ*8  per-requester write data, slice i = [i*8 +: 8]
- ack  out  NREQ  one-cycle pulse to the served requester
- err  out  1  one-cycle pulse with ack when the address is ≥ NREG
- wr_en  out  NREG  one-hot write enable to register instance addr
- wr_data  out  8  shared write data to all register instances
- busy  out  1  high in any state other than IDLE
- owner  out  OW  index of current/last granted requester; OW = max(1, clog2(NREQ))

## Operation
- FSM states: IDLE, WRITE, LOCKED.
- IDLE:
  - If any req is high, select the winner by round-robin, starting at last+1 mod NREQ.
  - Latch the winner's addr and wdata, set owner = winner and last = winner, then go to WRITE.
  - If no req is high, stay in IDLE.
- WRITE (exactly one cycle):
  - wr_data = latched data.
  - wr_en[latched addr] = 1 if addr < NREG; otherwise wr_en = 0 and err = 1.
  - ack[owner] = 1.
  - Increment the burst count.
  - Next state is LOCKED if lock[owner] = 1 and burst count < MAX_BURST; otherwise IDLE, and the burst count clears.
- LOCKED:
  - If req[owner] is high, latch that request and go to WRITE. Other requesters are ignored.
  - Else if lock[owner] is low, go to IDLE and clear the burst count.
  - Else stay in LOCKED.
- Handshake rules:
  - A requester holds req, addr and wdata stable until it samples ack high.
  - On that same edge it either drops req or presents its next transfer.
  - A req still high in the following cycle is treated as a new request.
- Burst count: width clog2(MAX_BURST+1); saturates and never wraps.
- Reset:
  - Next state IDLE, last = NREQ-1 (so requester 0 wins first), owner = 0, burst count = 0.
  - A write in flight when reset is sampled is dropped: no wr_en and no ack follow.
- Reset values of outputs: ack = 0, err = 0, wr_en = 0, wr_data = 0x00, busy = 0, owner = 0.
- Outputs are registered or decoded from state and latches only. They have no combinational path from req, addr or wdata.

## Timing
- Request sampled in IDLE or LOCKED at edge N → wr_en, wr_data and ack are valid for the whole cycle after edge N.
- A rising-edge register captures the data at edge N+1.
- wr_en is held for a full clock period, so negative-edge and level-type registers also see a full write window.
- Throughput: one write per 2 cycles, whether unlocked or locked.
- Simultaneous requests in IDLE: exactly one ack. The losers keep req high and are served in round-robin order on later passes.
- A lock asserted by a non-owner has no effect.
- A lock raised by the owner in the same cycle as WRITE counts, because it is sampled during WRITE.

## Structure
- Shared package/include regbank_pkg holds:
  - the state encoding constants (IDLE = 2'd0, WRITE = 2'd1, LOCKED = 2'd2)
  - the default NREG/AW values
  - the OW width function
- One combinational sub-module, rr_pick. Inputs: req vector and last index. Outputs: winner index and a valid flag. It is reusable by other arbiters.

## Test plan
- Reset, then req[0] with addr = 2, wdata = 0xA5 → one cycle later wr_en = 0b00000100, wr_data = 0xA5, ack = 01; the register captures 0xA5.
- req = 11 held continuously with distinct addr/data → ack alternates 01, 10, 01, with one write every 2 cycles; no requester is starved.
- Requester 1 with lock held issues 6 writes while req[0] is high → 4 writes to requester 1 (MAX_BURST), then return to IDLE and requester 0 is served next.
- addr = 9 with NREG = 8 → ack and err pulse together; wr_en stays 0 and no register changes.
- Reset asserted during WRITE → next cycle all outputs are zero and state is IDLE; a subsequent req[1] alone is granted normally.
- Owner drops lock in LOCKED with no req → IDLE next cycle, busy = 0, burst count cleared.
